// File: rtl/piezo_note_detect.sv
// piezo_note_detect
// Recovers the period of an asynchronous square wave (piezo drive line or
// external tone input) in clocks. The locked period is reported as
// note_per = period - 1, which is the same encoding the tone generator uses,
// so a detected value can be fed straight back to reproduce the tone.
//
// Flow: sig_in -> synchronizer -> registered rising-edge detect (rise) ->
// period counter -> IDLE / MEASURE / LOCKED state machine.
// A lock needs a candidate period followed by MATCH_CNT consecutive periods
// within TOL clocks of it. Once locked, small deviations are tolerated
// without touching note_per, so the reported value does not jitter.
module piezo_note_detect #(
    parameter int CNT_W     = 15,
    parameter int SYNC_STG  = 2,
    parameter int TOL       = 4,
    parameter int MATCH_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sig_in,
    output logic [CNT_W-1:0] note_per,
    output logic             valid,
    output logic             new_note,
    output logic             timeout
);

    // Width of the match counter; at least one bit even for MATCH_CNT = 1.
    localparam int MC_W = (MATCH_CNT < 2) ? 1 : $clog2(MATCH_CNT + 1);

    // Saturation value of the period counter; reaching it means no rise
    // arrived within the measurable range.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Tolerance widened to the difference width so the compare never wraps.
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);

    // Match count value that completes a lock on the next matching period.
    localparam logic [MC_W-1:0]  MC_LAST = MC_W'(MATCH_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Two periods count as equal when their unsigned distance is within TOL.
    // Both operands are zero-extended by one bit before subtracting so the
    // absolute difference is exact for every pair of CNT_W-bit values.
    function automatic logic within_tol(input logic [CNT_W-1:0] a,
                                        input logic [CNT_W-1:0] b);
        logic [CNT_W:0] ax;
        logic [CNT_W:0] bx;
        logic [CNT_W:0] diff;
        ax = {1'b0, a};
        bx = {1'b0, b};
        if (ax >= bx) begin
            diff = ax - bx;
        end else begin
            diff = bx - ax;
        end
        return (diff <= TOL_V);
    endfunction

    // Input conditioning
    logic [SYNC_STG-1:0] sync_r;
    logic                sync_last_r;
    logic                rise_r;

    // Period measurement and state
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cand_r;
    logic [MC_W-1:0]     mcnt_r;
    logic                have_cand_r;
    state_t              state_r;

    // Registered outputs
    logic [CNT_W-1:0]    note_per_r;
    logic                valid_r;
    logic                new_note_r;
    logic                timeout_r;

    // Decode helpers
    logic [CNT_W-1:0]    meas_s;
    logic                cnt_sat_s;
    logic                match_cand_s;
    logic                match_note_s;
    logic                timeout_evt_s;

    // Synchronize the asynchronous pin; cleared only by the hard reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STG-2:0], sig_in};
        end
    end

    // Registered rising-edge detect on the synchronized level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_last_r <= 1'b0;
            rise_r      <= 1'b0;
        end else begin
            sync_last_r <= sync_r[SYNC_STG-1];
            rise_r      <= sync_r[SYNC_STG-1] & ~sync_last_r;
        end
    end

    // The counter value seen in a rise cycle is the period minus one.
    assign meas_s    = cnt_r;
    assign cnt_sat_s = (cnt_r == CNT_MAX);

    // Tolerance matches against the candidate and against the locked period.
    always_comb begin
        match_cand_s = 1'b0;
        match_note_s = 1'b0;
        if (rise_r) begin
            match_cand_s = within_tol(meas_s, cand_r);
            match_note_s = within_tol(meas_s, note_per_r);
        end else begin
            match_cand_s = 1'b0;
            match_note_s = 1'b0;
        end
    end

    // A timeout only fires while tracking a tone and a rise takes precedence.
    always_comb begin
        timeout_evt_s = 1'b0;
        if ((state_r != ST_IDLE) && !rise_r && cnt_sat_s) begin
            timeout_evt_s = 1'b1;
        end else begin
            timeout_evt_s = 1'b0;
        end
    end

    // Period counter: zeroed on rise/clear/timeout, saturating count otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr || rise_r || timeout_evt_s) begin
            cnt_r <= '0;
        end else if ((state_r != ST_IDLE) && !cnt_sat_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Lock state machine with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cand_r      <= '0;
            mcnt_r      <= '0;
            have_cand_r <= 1'b0;
            note_per_r  <= '0;
            valid_r     <= 1'b0;
            new_note_r  <= 1'b0;
            timeout_r   <= 1'b0;
        end else if (clr) begin
            // Clear wins over everything except reset; note_per is kept.
            state_r     <= ST_IDLE;
            mcnt_r      <= '0;
            have_cand_r <= 1'b0;
            valid_r     <= 1'b0;
            new_note_r  <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            new_note_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_r) begin
                        // This rise only starts the first period.
                        state_r     <= ST_MEASURE;
                        timeout_r   <= 1'b0;
                        have_cand_r <= 1'b0;
                        mcnt_r      <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    if (rise_r) begin
                        if (!have_cand_r) begin
                            cand_r      <= meas_s;
                            have_cand_r <= 1'b1;
                            mcnt_r      <= '0;
                        end else if (match_cand_s) begin
                            if (mcnt_r == MC_LAST) begin
                                state_r    <= ST_LOCKED;
                                note_per_r <= meas_s;
                                valid_r    <= 1'b1;
                                new_note_r <= 1'b1;
                                mcnt_r     <= '0;
                            end else begin
                                mcnt_r <= mcnt_r + MC_W'(1);
                            end
                        end else begin
                            // Period changed: restart with this one as candidate.
                            cand_r <= meas_s;
                            mcnt_r <= '0;
                        end
                    end else if (cnt_sat_s) begin
                        state_r   <= ST_IDLE;
                        valid_r   <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= ST_MEASURE;
                    end
                end
                ST_LOCKED: begin
                    if (rise_r) begin
                        if (!match_note_s) begin
                            // Tone changed: drop valid, keep the old note_per.
                            state_r     <= ST_MEASURE;
                            cand_r      <= meas_s;
                            have_cand_r <= 1'b1;
                            mcnt_r      <= '0;
                            valid_r     <= 1'b0;
                        end else begin
                            state_r <= ST_LOCKED;
                        end
                    end else if (cnt_sat_s) begin
                        state_r   <= ST_IDLE;
                        valid_r   <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    valid_r     <= 1'b0;
                    have_cand_r <= 1'b0;
                    mcnt_r      <= '0;
                end
            endcase
        end
    end

    assign note_per = note_per_r;
    assign valid    = valid_r;
    assign new_note = new_note_r;
    assign timeout  = timeout_r;

endmodule
